// File: rtl/data_bus_responder.sv
// data_bus_responder
//   Responder end of the core's data-memory port. Decodes the byte address
//   from the Mem stage into a word-addressed data RAM and a small MMIO window
//   (LED register, synchronised switches, cycle counter, byte TX FIFO, status).
//
// Ports
//   CLK        clock, all state updates on posedge
//   Reset      synchronous, active-high
//   MemWrite   write strobe from core Mem stage
//   Addr       byte address, bits[1:0] ignored
//   WriteData  store data
//   ReadData   load data, combinational from Addr and current state
//   SW         raw board switches (asynchronous)
//   LED        LED register
//   tx_data    FIFO head byte
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts head this cycle
//
// MMIO offsets: 0x00 LED rw | 0x04 SW ro | 0x08 CYCLE rw | 0x0C TXDATA wo | 0x10 STATUS rw
// STATUS: {20'b0, count[7:0], OVF, ERR, EMPTY, FULL}

module data_bus_responder #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0800,
    parameter int unsigned DMEM_WORDS = 128,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_0C00,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [15:0] SW,
    output logic [15:0] LED,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] DMEM_END  = DMEM_BASE + 32'(4 * DMEM_WORDS);
    localparam logic [31:0] MMIO_SPAN = 32'h0000_0014;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_CYCLE,
        SEL_TXDATA,
        SEL_STATUS
    } sel_e;

    sel_e        sel;
    logic [31:0] mmioOff;
    logic [AW-1:0] ramIdx;

    logic [31:0] ram [DMEM_WORDS];

    logic [15:0] ledReg;
    logic [15:0] swSync1;
    logic [15:0] swSync2;
    logic [31:0] cycleCnt;

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          err;

    logic fifoFull;
    logic fifoEmpty;
    logic doPop;
    logic pushReq;
    logic doPush;
    logic ovfSet;
    logic ovfClr;
    logic errSet;
    logic errClr;

    // Address decode. Both windows are word aligned, so comparing the full
    // byte address gives the same result as comparing with bits[1:0] masked.
    always_comb begin
        mmioOff = Addr - MMIO_BASE;
        ramIdx  = AW'((Addr - DMEM_BASE) >> 2);
        sel     = SEL_NONE;
        if (Addr >= DMEM_BASE && Addr < DMEM_END) begin
            sel = SEL_RAM;
        end else if (mmioOff < MMIO_SPAN) begin
            case (mmioOff[4:2])
                3'd0:    sel = SEL_LED;
                3'd1:    sel = SEL_SW;
                3'd2:    sel = SEL_CYCLE;
                3'd3:    sel = SEL_TXDATA;
                3'd4:    sel = SEL_STATUS;
                default: sel = SEL_NONE;
            endcase
        end
    end

    // FIFO control. A full FIFO still accepts a push when the head leaves in
    // the same cycle; an empty FIFO never pops, even with tx_ready high.
    always_comb begin
        fifoFull  = (count == CW'(FIFO_DEPTH));
        fifoEmpty = (count == '0);
        doPop     = !fifoEmpty && tx_ready;
        pushReq   = MemWrite && (sel == SEL_TXDATA);
        doPush    = pushReq && (!fifoFull || doPop);
        ovfSet    = pushReq && !doPush;
        ovfClr    = MemWrite && (sel == SEL_STATUS) && WriteData[3];
        errSet    = MemWrite && (sel == SEL_NONE);
        errClr    = MemWrite && (sel == SEL_STATUS) && WriteData[2];
    end

    // Data RAM: no reset, contents survive Reset.
    always_ff @(posedge CLK) begin
        if (MemWrite && sel == SEL_RAM) begin
            ram[ramIdx] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (doPush && !Reset) begin
            fifoMem[wrPtr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ledReg   <= '0;
            swSync1  <= '0;
            swSync2  <= '0;
            cycleCnt <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            swSync1 <= SW;
            swSync2 <= swSync1;

            if (MemWrite && sel == SEL_LED) begin
                ledReg <= WriteData[15:0];
            end

            if (MemWrite && sel == SEL_CYCLE) begin
                cycleCnt <= '0;
            end else begin
                cycleCnt <= cycleCnt + 32'd1;
            end

            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Set events take priority over a same-cycle clear.
            if (ovfSet) begin
                ovf <= 1'b1;
            end else if (ovfClr) begin
                ovf <= 1'b0;
            end
            if (errSet) begin
                err <= 1'b1;
            end else if (errClr) begin
                err <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:    ReadData = ram[ramIdx];
            SEL_LED:    ReadData = {16'b0, ledReg};
            SEL_SW:     ReadData = {16'b0, swSync2};
            SEL_CYCLE:  ReadData = cycleCnt;
            SEL_STATUS: ReadData = {20'b0, 8'(count), ovf, err, fifoEmpty, fifoFull};
            default:    ReadData = '0;
        endcase
    end

    assign LED      = ledReg;
    assign tx_data  = fifoMem[rdPtr];
    assign tx_valid = !fifoEmpty;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder
//   Directed scenarios followed by a randomized phase, all checked against a
//   behavioural model of the memory map (RAM as an associative array, TX FIFO
//   as a queue, switch synchroniser as a sample history).

module tb_data_bus_responder;

    localparam logic [31:0] A_RAM    = 32'h0000_0810;
    localparam logic [31:0] A_LED    = 32'h0000_0C00;
    localparam logic [31:0] A_SW     = 32'h0000_0C04;
    localparam logic [31:0] A_CYCLE  = 32'h0000_0C08;
    localparam logic [31:0] A_TX     = 32'h0000_0C0C;
    localparam logic [31:0] A_STATUS = 32'h0000_0C10;
    localparam logic [31:0] A_UNMAP  = 32'h0000_0400;

    logic        CLK;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] SW;
    logic [15:0] LED;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic [31:0] mRam [int unsigned];
    logic [15:0] mLed;
    logic [31:0] mCyc;
    logic [7:0]  mQ [$];
    logic        mOvf;
    logic        mErr;
    logic [15:0] mSwH [$];

    logic [31:0] rd;

    data_bus_responder #(
        .DMEM_BASE (32'h0000_0800),
        .DMEM_WORDS(128),
        .MMIO_BASE (32'h0000_0C00),
        .FIFO_DEPTH(8)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .SW       (SW),
        .LED      (LED),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 unmapped, 1 RAM, 2 LED, 3 SW, 4 CYCLE, 5 TXDATA, 6 STATUS
    function automatic int region(input logic [31:0] a);
        if (a >= 32'h800 && a < 32'hA00) return 1;
        if (a >= 32'hC00 && a < 32'hC14) return int'((a - 32'hC00) / 4) + 2;
        return 0;
    endfunction

    function automatic int unsigned ramIndex(input logic [31:0] a);
        return int'((a - 32'h800) / 4);
    endfunction

    task automatic modelReset();
        mLed = '0;
        mCyc = '0;
        mQ.delete();
        mOvf = 1'b0;
        mErr = 1'b0;
        mSwH.delete();
        mSwH.push_back(16'h0);
        mSwH.push_back(16'h0);
    endtask

    // One bus cycle: drive, check pre-edge view against the model, clock,
    // then advance the model.
    task automatic cyc(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, output logic [31:0] rdOut);
        int          r;
        logic [31:0] exp;
        logic        known;
        logic        pop;
        logic        accept;
        logic        ovfSet;
        logic [15:0] swNow;
        int unsigned n;

        Reset     = rst;
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
        tx_ready  = rdy;
        #1;
        rdOut = ReadData;
        r     = region(a);
        n     = mQ.size();
        known = 1'b1;
        case (r)
            1: begin
                known = mRam.exists(ramIndex(a));
                exp   = known ? mRam[ramIndex(a)] : 32'h0;
            end
            2: exp = {16'h0, mLed};
            3: exp = {16'h0, mSwH[mSwH.size() - 2]};
            4: exp = mCyc;
            6: exp = {20'h0, 8'(n), mOvf, mErr, (n == 0), (n == 8)};
            default: exp = 32'h0;
        endcase
        if (known) check("rdata", rdOut, exp);
        check("led", {16'h0, LED}, {16'h0, mLed});
        check("tx_valid", {31'h0, tx_valid}, {31'h0, (n != 0)});
        if (n != 0) check("tx_data", {24'h0, tx_data}, {24'h0, mQ[0]});
        swNow = SW;

        @(posedge CLK);

        if (we && r == 1) mRam[ramIndex(a)] = d;
        if (rst) begin
            modelReset();
        end else begin
            pop    = (n != 0) && rdy;
            accept = we && r == 5 && (n < 8 || pop);
            ovfSet = we && r == 5 && !accept;
            if (pop) void'(mQ.pop_front());
            if (accept) mQ.push_back(d[7:0]);
            if (we && r == 2) mLed = d[15:0];
            mCyc = (we && r == 4) ? 32'h0 : mCyc + 32'd1;
            if (ovfSet) mOvf = 1'b1;
            else if (we && r == 6 && d[3]) mOvf = 1'b0;
            if (we && r == 0) mErr = 1'b1;
            else if (we && r == 6 && d[2]) mErr = 1'b0;
            mSwH.push_back(swNow);
            if (mSwH.size() > 4) void'(mSwH.pop_front());
        end
        #1;
    endtask

    initial begin
        Reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
        SW        = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        modelReset();

        // Reset state
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("rst_status", rd, 32'h0000_0002);
        cyc(0, 0, A_CYCLE, 0, 0, rd);
        check("rst_cycle", rd, 32'h0000_0001);

        // RAM write/read, sub-word address alias, unmapped read
        cyc(0, 1, A_RAM, 32'hA5A5_1234, 0, rd);
        cyc(0, 0, A_RAM, 0, 0, rd);
        check("ram_rd", rd, 32'hA5A5_1234);
        cyc(0, 0, A_RAM + 2, 0, 0, rd);
        check("ram_rd_unaligned", rd, 32'hA5A5_1234);
        cyc(0, 0, A_UNMAP, 0, 0, rd);
        check("unmapped_rd", rd, 32'h0);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("err_after_rd", {31'h0, rd[2]}, 32'h0);

        // LED and switch synchroniser latency
        cyc(0, 1, A_LED, 32'h0000_BEEF, 0, rd);
        check("led_out", {16'h0, LED}, 32'h0000_BEEF);
        SW = 16'h00F0;
        cyc(0, 0, A_SW, 0, 0, rd);
        check("sw_edge0", rd, 32'h0);
        cyc(0, 0, A_SW, 0, 0, rd);
        check("sw_edge1", rd, 32'h0);
        cyc(0, 0, A_SW, 0, 0, rd);
        check("sw_edge2", rd, 32'h0000_00F0);

        // Overflow with consumer stalled, then drain in order
        for (int unsigned i = 1; i <= 9; i++) cyc(0, 1, A_TX, i, 0, rd);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("full_status", rd, 32'h0000_0089);
        for (int unsigned i = 1; i <= 8; i++) begin
            check("drain_data", {24'h0, tx_data}, i);
            cyc(0, 0, A_UNMAP, 0, 1, rd);
        end
        check("drain_valid", {31'h0, tx_valid}, 32'h0);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("empty_status", rd, 32'h0000_000A);
        cyc(0, 1, A_STATUS, 32'h8, 0, rd);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("ovf_clear", rd, 32'h0000_0002);

        // Push into a full FIFO while the head is popped
        for (int unsigned i = 0; i < 8; i++) cyc(0, 1, A_TX, 32'h11 + i, 0, rd);
        cyc(0, 1, A_TX, 32'h55, 1, rd);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("push_pop_full", rd, 32'h0000_0081);
        check("push_pop_head", {24'h0, tx_data}, 32'h12);
        repeat (8) cyc(0, 0, A_UNMAP, 0, 1, rd);
        check("drain2_valid", {31'h0, tx_valid}, 32'h0);

        // Cycle counter reset by write
        cyc(0, 1, A_CYCLE, 32'hDEAD_BEEF, 0, rd);
        repeat (10) cyc(0, 0, A_UNMAP, 0, 0, rd);
        cyc(0, 0, A_CYCLE, 0, 0, rd);
        check("cycle_10", rd, 32'd10);

        // Unmapped write sets ERR, STATUS write clears it
        cyc(0, 1, A_UNMAP, 32'h1, 0, rd);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("err_set", rd, 32'h0000_0006);
        cyc(0, 1, A_STATUS, 32'h4, 0, rd);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("err_clear", rd, 32'h0000_0002);

        // Reset mid-stream with a push in flight
        cyc(0, 1, A_LED, 32'h1234, 0, rd);
        for (int unsigned i = 0; i < 5; i++) cyc(0, 1, A_TX, 32'hA0 + i, 0, rd);
        cyc(1, 1, A_TX, 32'h77, 1, rd);
        check("rst_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_led", {16'h0, LED}, 32'h0);
        cyc(0, 0, A_STATUS, 0, 0, rd);
        check("rst_status2", rd, 32'h0000_0002);
        cyc(0, 0, A_RAM, 0, 0, rd);
        check("ram_keep", rd, 32'hA5A5_1234);

        // Randomized traffic against the model
        for (int unsigned k = 0; k < 600; k++) begin
            logic [31:0] a;
            logic        we;
            logic        rdy;
            logic        rst;
            case ($urandom_range(0, 9))
                0, 1:    a = 32'h800 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                2:       a = A_LED + $urandom_range(0, 3);
                3:       a = A_SW + $urandom_range(0, 3);
                4:       a = A_CYCLE + $urandom_range(0, 3);
                5, 6, 7: a = A_TX + $urandom_range(0, 3);
                8:       a = A_STATUS + $urandom_range(0, 3);
                default: a = ($urandom_range(0, 1) == 0) ? 32'h400 + $urandom_range(0, 255)
                                                         : 32'hC14 + $urandom_range(0, 255);
            endcase
            we  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) SW = 16'($urandom);
            cyc(rst, we, a, $urandom, rdy, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
